fp16_recip_mul_pipe: RTL and testbench

FP16_RECIP_MUL_PIPE -- requirements
Module: fp16_recip_mul_pipe

---
 rtl/fp16_sfu_pkg.sv | 56 +++++
 rtl/fp16_mant_mul.sv | 12 +
 rtl/fp16_recip_mul_pipe.sv | 144 ++++++++++++++
 tb/tb_fp16_recip_mul_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_sfu_pkg.sv
// Shared FP16 definitions for the special-function pipeline.
// Field widths, classification and inter-stage bundles.
package fp16_sfu_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int BIAS   = 15;
    localparam int EXP_MAX = 31;
    localparam logic [15:0] QNAN = 16'h7E00;

    typedef struct packed {
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] man;
    } fp16_class_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_t;

    typedef struct packed {
        special_t          sp;
        logic              sign;
        logic signed [6:0] exp;
        logic [SIG_W-1:0]  ma;
        logic [SIG_W-1:0]  mr;
    } s1_t;

    typedef struct packed {
        special_t          sp;
        logic              sign;
        logic signed [6:0] exp;
        logic [PROD_W-1:0] prod;
    } s2_t;

    // Exponent field 0 is treated as zero: subnormals are flushed.
    function automatic fp16_class_t classify(input logic [15:0] x);
        fp16_class_t c;
        c.sign    = x[15];
        c.exp     = x[14:10];
        c.is_zero = (x[14:10] == '0);
        c.is_inf  = (&x[14:10]) && (x[9:0] == '0);
        c.is_nan  = (&x[14:10]) && (|x[9:0]);
        c.man     = {1'b1, x[9:0]};
        return c;
    endfunction

endpackage

// File: rtl/fp16_mant_mul.sv
// Unsigned 11x11 significand multiplier, combinational.
module fp16_mant_mul
    import fp16_sfu_pkg::*;
(
    input  logic [SIG_W-1:0]  a,
    input  logic [SIG_W-1:0]  b,
    output logic [PROD_W-1:0] p
);

    assign p = {{(PROD_W-SIG_W){1'b0}}, a} * {{(PROD_W-SIG_W){1'b0}}, b};

endmodule

// File: rtl/fp16_recip_mul_pipe.sv
// Three-stage elastic FP16 multiply of a dividend by a reciprocal.
// Each stage advances when empty or when its successor advances.
module fp16_recip_mul_pipe
    import fp16_sfu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      a_i,
    input  logic [15:0]      recip_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [15:0]      result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [2:0]       flags_o,
    output logic             valid_o,
    input  logic             ready_i
);

    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [TAG_W-1:0] tag1, tag2, tag3;
    logic [15:0] res_d, res_q;
    logic [2:0]  flags_d, flags_q;
    fp16_class_t ca, cr;
    logic [PROD_W-1:0] prod;

    assign adv3    = !v3 || ready_i;
    assign adv2    = !v2 || adv3;
    assign adv1    = !v1 || adv2;
    assign ready_o = adv1;

    always_comb begin
        ca = classify(a_i);
        cr = classify(recip_i);
        s1_d.sign = ca.sign ^ cr.sign;
        s1_d.exp  = $signed({2'b00, ca.exp}) + $signed({2'b00, cr.exp})
                  - $signed(7'(BIAS));
        s1_d.ma   = ca.man;
        s1_d.mr   = cr.man;
        if (ca.is_nan || cr.is_nan || (ca.is_inf && cr.is_zero) ||
            (ca.is_zero && cr.is_inf))
            s1_d.sp = SP_NAN;
        else if (ca.is_inf || cr.is_inf)
            s1_d.sp = SP_INF;
        else if (ca.is_zero || cr.is_zero)
            s1_d.sp = SP_ZERO;
        else
            s1_d.sp = SP_NONE;
    end

    fp16_mant_mul u_mul (
        .a (s1_q.ma),
        .b (s1_q.mr),
        .p (prod)
    );

    always_comb begin
        s2_d.sp   = s1_q.sp;
        s2_d.sign = s1_q.sign;
        s2_d.exp  = s1_q.exp;
        s2_d.prod = prod;
    end

    logic              n, guard, sticky, round_up;
    logic [MAN_W-1:0]  frac;
    logic [MAN_W:0]    frac_r;
    logic signed [6:0] e_fin;

    always_comb begin
        n        = s2_q.prod[21];
        frac     = n ? s2_q.prod[20:11] : s2_q.prod[19:10];
        guard    = n ? s2_q.prod[10] : s2_q.prod[9];
        sticky   = n ? (|s2_q.prod[9:0]) : (|s2_q.prod[8:0]);
        round_up = guard && (sticky || frac[0]);
        frac_r   = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        // A rounding carry leaves frac_r[9:0] zero and bumps the exponent.
        e_fin    = $signed(s2_q.exp) + $signed({6'b0, n})
                 + $signed({6'b0, frac_r[MAN_W]});
        res_d    = '0;
        flags_d  = '0;
        unique case (s2_q.sp)
            SP_NAN: begin
                res_d   = QNAN;
                flags_d = 3'b100;
            end
            SP_INF:  res_d = {s2_q.sign, 5'h1F, 10'h000};
            SP_ZERO: res_d = {s2_q.sign, 15'h0000};
            default: begin
                if (e_fin >= 7'sd31) begin
                    res_d   = {s2_q.sign, 5'h1F, 10'h000};
                    flags_d = 3'b010;
                end else if (e_fin <= 7'sd0) begin
                    res_d   = {s2_q.sign, 15'h0000};
                    flags_d = 3'b001;
                end else begin
                    res_d = {s2_q.sign, e_fin[4:0], frac_r[MAN_W-1:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            tag1    <= '0;
            tag2    <= '0;
            tag3    <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            if (adv1) begin
                v1   <= valid_i;
                s1_q <= s1_d;
                tag1 <= tag_i;
            end
            if (adv2) begin
                v2   <= v1;
                s2_q <= s2_d;
                tag2 <= tag1;
            end
            if (adv3) begin
                v3      <= v2;
                res_q   <= res_d;
                flags_q <= flags_d;
                tag3    <= tag2;
            end
        end
    end

    assign valid_o  = v3;
    assign result_o = res_q;
    assign tag_o    = tag3;
    assign flags_o  = flags_q;

endmodule

// File: tb/tb_fp16_recip_mul_pipe.sv
// Scoreboard bench for fp16_recip_mul_pipe: driver queues expectations,
// a negedge monitor pops and compares on each output transfer.
module tb_fp16_recip_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_i, recip_i;
    logic [3:0]  tag_i;
    logic        valid_i, ready_o;
    logic [15:0] result_o;
    logic [3:0]  tag_o;
    logic [2:0]  flags_o;
    logic        valid_o, ready_i;

    fp16_recip_mul_pipe #(.TAG_W(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .a_i      (a_i),
        .recip_i  (recip_i),
        .tag_i    (tag_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .result_o (result_o),
        .tag_o    (tag_o),
        .flags_o  (flags_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic [2:0]  flags;
        int          issue;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] r;
        logic [15:0] res;
        logic [2:0]  fl;
    } vec_t;

    exp_t sbq[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    logic        hold_v = 1'b0;
    logic [15:0] hold_res;
    logic [3:0]  hold_tag;
    logic [2:0]  hold_fl;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", {31'b0, valid_o}, 32'd1);
                check("hold_result", {16'b0, result_o}, {16'b0, hold_res});
                check("hold_tag", {28'b0, tag_o}, {28'b0, hold_tag});
                check("hold_flags", {29'b0, flags_o}, {29'b0, hold_fl});
            end
            if (valid_o && ready_i) begin
                if (sbq.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_output: got %0h required none",
                             result_o);
                end else begin
                    e = sbq.pop_front();
                    check("result", {16'b0, result_o}, {16'b0, e.res});
                    check("tag", {28'b0, tag_o}, {28'b0, e.tag});
                    check("flags", {29'b0, flags_o}, {29'b0, e.flags});
                    if (e.chk_lat)
                        check("latency", cyc - e.issue, 32'd3);
                end
            end
            hold_v   = valid_o && !ready_i;
            hold_res = result_o;
            hold_tag = tag_o;
            hold_fl  = flags_o;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] r,
                        input logic [3:0] t, input logic [15:0] res,
                        input logic [2:0] fl, input bit lat);
        exp_t e;
        bit   done;
        a_i     = a;
        recip_i = r;
        tag_i   = t;
        valid_i = 1'b1;
        done    = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (ready_o) begin
                e.res = res;
                e.tag = t;
                e.flags = fl;
                e.issue = cyc;
                e.chk_lat = lat;
                sbq.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            ncmp++;
            nerr++;
            $display("FAIL send_timeout: got ready_o=0 required 1");
        end
        valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sbq.size() != 0; k++)
            @(negedge clk);
        check("drain_empty", sbq.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vt [0:17];

    initial begin
        vt = '{
            '{16'h3E00, 16'h3E00, 16'h4080, 3'b000},
            '{16'h3C01, 16'h3C01, 16'h3C02, 3'b000},
            '{16'h3C01, 16'h3E00, 16'h3E02, 3'b000},
            '{16'h3FFE, 16'h3C01, 16'h4000, 3'b000},
            '{16'hC000, 16'h3800, 16'hBC00, 3'b000},
            '{16'h7800, 16'h4000, 16'h7C00, 3'b010},
            '{16'hF800, 16'h4000, 16'hFC00, 3'b010},
            '{16'h7BFF, 16'h3C01, 16'h7C00, 3'b010},
            '{16'h0400, 16'h0400, 16'h0000, 3'b001},
            '{16'h0400, 16'h3800, 16'h0000, 3'b001},
            '{16'h0400, 16'h3C00, 16'h0400, 3'b000},
            '{16'h7C00, 16'h0000, 16'h7E00, 3'b100},
            '{16'h8000, 16'h3C00, 16'h8000, 3'b000},
            '{16'h7C00, 16'hC000, 16'hFC00, 3'b000},
            '{16'h7E00, 16'h3C00, 16'h7E00, 3'b100},
            '{16'h3C00, 16'h7D00, 16'h7E00, 3'b100},
            '{16'h0200, 16'h3C00, 16'h0000, 3'b000},
            '{16'h0000, 16'h7C00, 16'h7E00, 3'b100}
        };
        rst     = 1'b1;
        a_i     = '0;
        recip_i = '0;
        tag_i   = '0;
        valid_i = 1'b0;
        ready_i = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_valid_o", {31'b0, valid_o}, 32'd0);
        check("rst_ready_o", {31'b0, ready_o}, 32'd1);
        check("rst_result", {16'b0, result_o}, 32'd0);
        check("rst_tag", {28'b0, tag_o}, 32'd0);
        check("rst_flags", {29'b0, flags_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(16'h3C00, 16'h3800, 4'd5, 16'h3800, 3'b000, 1'b1);
        drain();

        foreach (vt[i])
            send(vt[i].a, vt[i].r, 4'(i), vt[i].res, vt[i].fl, 1'b1);
        drain();

        // Stall: fill all three stages with the output held off.
        ready_i = 1'b0;
        send(16'h4000, 16'h4200, 4'd1, 16'h4600, 3'b000, 1'b0);
        send(16'h4400, 16'h3400, 4'd2, 16'h3C00, 3'b000, 1'b0);
        send(16'h3C00, 16'h3C00, 4'd3, 16'h3C00, 3'b000, 1'b0);
        @(negedge clk);
        check("stall_ready_o", {31'b0, ready_o}, 32'd0);
        check("stall_valid_o", {31'b0, valid_o}, 32'd1);
        @(posedge clk);
        #1 ready_i = 1'b1;
        drain();

        // Reset with two operations in flight.
        send(16'h4000, 16'h4000, 4'd8, 16'h4400, 3'b000, 1'b1);
        send(16'h4200, 16'h4000, 4'd9, 16'h4600, 3'b000, 1'b1);
        sbq.delete();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst_valid_o", {31'b0, valid_o}, 32'd0);
            check("midrst_result", {16'b0, result_o}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_idle", {31'b0, valid_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'hBC00, 16'h4000, 4'd12, 16'hC000, 3'b000, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
